// File: rtl/store_unit.sv
// Store unit: computes the effective address, aligns store data into byte lanes and
// runs a single valid/ready write. Optional misalignment trap under MISALIGN_TRAP_EN.
module store_unit (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        store_enable,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_value,
   input  logic [31:0] rs2_value,
   input  logic [31:0] immediate12,
   output logic        busy,
   output logic        done,
   output logic        mem_write_valid,
   input  logic        mem_write_ready,
   output logic [31:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [3:0]  mem_write_strobe,
   output logic        misaligned
);

   typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] ea;
   logic [1:0]  lane_off;
   logic        is_sb, is_sh, is_sw, f3_valid, trap;
   logic        accept;
   logic [31:0] data_d, data_q;
   logic [3:0]  strb_d, strb_q;
   logic [29:0] word_addr_q;
   logic        mis_q;

   // Carry out of the address add is intentionally discarded.
   assign ea       = rs1_value + immediate12;
   assign is_sb    = (funct3 == 3'h0);
   assign is_sh    = (funct3 == 3'h1);
   assign is_sw    = (funct3 == 3'h2);
   assign f3_valid = is_sb | is_sh | is_sw;
   assign accept   = (state == IDLE) && store_enable;

`ifdef MISALIGN_TRAP_EN
   assign trap     = (is_sh & ea[0]) | (is_sw & (ea[1:0] != 2'b00));
   assign lane_off = ea[1:0];
`else
   // Without the trap, low address bits that break alignment are simply dropped.
   assign trap     = 1'b0;
   assign lane_off = is_sw ? 2'b00 : (is_sh ? {ea[1], 1'b0} : ea[1:0]);
`endif

   always_comb begin
      strb_d = 4'b1111;
      data_d = rs2_value;
      if (is_sb) begin
         strb_d = 4'b0001 << lane_off;
         data_d = {4{rs2_value[7:0]}};
      end else if (is_sh) begin
         strb_d = lane_off[1] ? 4'b1100 : 4'b0011;
         data_d = {2{rs2_value[15:0]}};
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (store_enable) begin
               if (!f3_valid || trap) state_nxt = DONE;
               else                   state_nxt = REQUEST;
            end
         end
         REQUEST: begin
            if (mem_write_ready) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         mis_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) mis_q <= f3_valid & trap;
      end
   end

   // Payload registers carry no reset; every output path is gated by state.
   always_ff @(posedge clock) begin
      if (accept) begin
         word_addr_q <= ea[31:2];
         data_q      <= data_d;
         strb_q      <= strb_d;
      end
   end

   assign busy              = (state != IDLE);
   assign done              = (state == DONE);
   assign mem_write_valid   = (state == REQUEST);
   assign mem_write_address = mem_write_valid ? {word_addr_q, 2'b00} : 32'h0;
   assign mem_write_data    = mem_write_valid ? data_q : 32'h0;
   assign mem_write_strobe  = mem_write_valid ? strb_q : 4'b0000;
   assign misaligned        = done & mis_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: expected writes are queued when a store is issued
// and compared when the DUT presents its request.
module tb_store_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        store_enable;
   logic [2:0]  funct3;
   logic [31:0] rs1_value, rs2_value, immediate12;
   logic        busy, done, mem_write_valid, mem_write_ready;
   logic [31:0] mem_write_address, mem_write_data;
   logic [3:0]  mem_write_strobe;
   logic        misaligned;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } txn_t;

   txn_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   store_unit dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .store_enable      (store_enable),
      .funct3            (funct3),
      .rs1_value         (rs1_value),
      .rs2_value         (rs2_value),
      .immediate12       (immediate12),
      .busy              (busy),
      .done              (done),
      .mem_write_valid   (mem_write_valid),
      .mem_write_ready   (mem_write_ready),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_write_strobe  (mem_write_strobe),
      .misaligned        (misaligned)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one store and follow it to its done pulse. Called at a falling edge.
   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic [31:0] rs2, input int stall,
                           input logic noise, input logic req, input logic mis,
                           input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      txn_t t;
      @(negedge clock);
      funct3 = f3; rs1_value = rs1; immediate12 = imm; rs2_value = rs2;
      store_enable = 1'b1;
      mem_write_ready = 1'b0;
      if (req) begin
         t.addr = addr; t.data = data; t.strb = strb;
         exp_q.push_back(t);
      end
      @(negedge clock);
      store_enable = 1'b0;
      if (req) begin
         for (int i = 0; i <= stall; i++) begin
            check({tag, " valid"}, {31'b0, mem_write_valid}, 32'd1);
            check({tag, " busy"},  {31'b0, busy}, 32'd1);
            check({tag, " done_early"}, {31'b0, done}, 32'd0);
            if (exp_q.size() == 0) begin
               check({tag, " queue_empty"}, 32'd0, 32'd1);
            end else begin
               check({tag, " addr"}, mem_write_address, exp_q[0].addr);
               check({tag, " data"}, mem_write_data, exp_q[0].data);
               check({tag, " strb"}, {28'b0, mem_write_strobe}, {28'b0, exp_q[0].strb});
            end
            mem_write_ready = (i == stall);
            store_enable    = noise;
            @(negedge clock);
         end
         store_enable = 1'b0;
         mem_write_ready = 1'b0;
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      check({tag, " done"}, {31'b0, done}, 32'd1);
      check({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, mis});
      check({tag, " valid_in_done"}, {31'b0, mem_write_valid}, 32'd0);
      check({tag, " strb_in_done"}, {28'b0, mem_write_strobe}, 32'd0);
   endtask

   initial begin
      reset_n = 1'b0; store_enable = 1'b0; funct3 = 3'h0;
      rs1_value = '0; rs2_value = '0; immediate12 = '0; mem_write_ready = 1'b0;
      #1;
      check("rst busy",  {31'b0, busy}, 32'd0);
      check("rst done",  {31'b0, done}, 32'd0);
      check("rst valid", {31'b0, mem_write_valid}, 32'd0);
      check("rst addr",  mem_write_address, 32'd0);
      check("rst data",  mem_write_data, 32'd0);
      check("rst strb",  {28'b0, mem_write_strobe}, 32'd0);
      check("rst mis",   {31'b0, misaligned}, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      do_store("sb_off3", 3'h0, 32'h1000, 32'h3, 32'h0000_00A5, 0, 1'b0, 1'b1, 1'b0,
               32'h1000, 32'hA5A5_A5A5, 4'b1000);
      do_store("sh_neg", 3'h1, 32'h2000, 32'hFFFF_FFFE, 32'h1234_BEEF, 0, 1'b0, 1'b1, 1'b0,
               32'h1FFC, 32'hBEEF_BEEF, 4'b1100);
      do_store("sw_stall", 3'h2, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, 1'b1, 1'b1, 1'b0,
               32'h100, 32'hDEAD_BEEF, 4'b1111);
`ifdef MISALIGN_TRAP_EN
      do_store("sw_mis", 3'h2, 32'h100, 32'h2, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 1'b1,
               32'h0, 32'h0, 4'b0000);
      do_store("sh_mis", 3'h1, 32'h40, 32'h1, 32'h0000_1111, 0, 1'b0, 1'b0, 1'b1,
               32'h0, 32'h0, 4'b0000);
`else
      do_store("sw_mis", 3'h2, 32'h100, 32'h2, 32'hCAFE_F00D, 0, 1'b0, 1'b1, 1'b0,
               32'h100, 32'hCAFE_F00D, 4'b1111);
      do_store("sh_mis", 3'h1, 32'h40, 32'h1, 32'h0000_1111, 0, 1'b0, 1'b1, 1'b0,
               32'h40, 32'h1111_1111, 4'b0011);
`endif
      do_store("bad_f3", 3'h4, 32'h100, 32'h0, 32'h1, 0, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h0, 4'b0000);
      do_store("sb_off1", 3'h0, 32'h20, 32'h1, 32'h0000_003C, 1, 1'b0, 1'b1, 1'b0,
               32'h20, 32'h3C3C_3C3C, 4'b0010);
      do_store("sh_low", 3'h1, 32'h40, 32'h0, 32'hAAAA_5555, 0, 1'b0, 1'b1, 1'b0,
               32'h40, 32'h5555_5555, 4'b0011);
      do_store("sw_wrap", 3'h2, 32'hFFFF_FFFF, 32'h5, 32'h0123_4567, 0, 1'b0, 1'b1, 1'b0,
               32'h4, 32'h0123_4567, 4'b1111);

      @(negedge clock);
      check("idle busy", {31'b0, busy}, 32'd0);
      check("idle done", {31'b0, done}, 32'd0);

      // Reset in the middle of a stalled request.
      funct3 = 3'h2; rs1_value = 32'h500; immediate12 = 32'h0; rs2_value = 32'h5555_AAAA;
      store_enable = 1'b1; mem_write_ready = 1'b0;
      @(negedge clock);
      store_enable = 1'b0;
      check("pre_rst valid", {31'b0, mem_write_valid}, 32'd1);
      check("pre_rst addr", mem_write_address, 32'h500);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst valid", {31'b0, mem_write_valid}, 32'd0);
      check("mid_rst busy",  {31'b0, busy}, 32'd0);
      check("mid_rst addr",  mem_write_address, 32'd0);
      check("mid_rst data",  mem_write_data, 32'd0);
      check("mid_rst strb",  {28'b0, mem_write_strobe}, 32'd0);
      mem_write_ready = 1'b1;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("post_rst done",  {31'b0, done}, 32'd0);
         check("post_rst valid", {31'b0, mem_write_valid}, 32'd0);
      end
      mem_write_ready = 1'b0;

      do_store("sb_after_rst", 3'h0, 32'h300, 32'h2, 32'h0000_007E, 0, 1'b0, 1'b1, 1'b0,
               32'h300, 32'h7E7E_7E7E, 4'b0100);

      check("queue_drained", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have these ports (name, direction, width, meaning), with clock and reset first:
- clock  in  1: single clock; all state updates on rising edge.
- reset_n  in  1: asynchronous, active-low reset.
- store_enable  in  1: start request; sampled only in IDLE.
- funct3  in  3: store type; SB=3'h0, SH=3'h1, SW=3'h2.
- rs1_value  in  32: base address.
- rs2_value  in  32: store data source.
- immediate12  in  32: sign-extended offset.
- busy  out  1: high when state is not IDLE.
- done  out  1: one-cycle completion pulse.
- mem_write_valid  out  1: write request valid.
- mem_write_ready  in  1: memory accepts the request.
- mem_write_address  out  32: word address, bits [1:0] always 0.
- mem_write_data  out  32: lane-aligned write data.
- mem_write_strobe  out  4: byte enables; bit k enables bits [8k+7:8k].
- misaligned  out  1: fault flag, valid while done=1.

Function
REQ-002 SHALL implement FSM states IDLE, REQUEST, DONE.
REQ-003 IDLE with store_enable=1 SHALL latch ea = rs1_value + immediate12 (mod 2^32, carry discarded), decode funct3, and go to REQUEST (or DONE per REQ-009/010).
REQ-004 store_enable SHALL be ignored outside IDLE; no queuing.
REQ-005 Lane rules, offset = ea[1:0]:
- SB: strobe = 4'b0001 << offset; data = {4{rs2_value[7:0]}}.
- SH: strobe = 4'b0011 (ea[1]=0) or 4'b1100 (ea[1]=1); data = {2{rs2_value[15:0]}}.
- SW: strobe = 4'b1111; data = rs2_value.
REQ-006 mem_write_address SHALL be {ea[31:2], 2'b00}.
REQ-007 REQUEST SHALL drive mem_write_valid=1 with address, data and strobe held stable until mem_write_ready=1 on a rising edge; the FSM SHALL then go to DONE.
REQ-008 DONE SHALL assert done=1 for exactly one cycle, deassert mem_write_valid, and return to IDLE.
REQ-009 funct3 not in {0,1,2} SHALL skip REQUEST: no memory request, go directly to DONE with misaligned=0.
REQ-010 Latency: store_enable at edge N gives mem_write_valid in cycle N+1; with ready already high, done in cycle N+2; each stall cycle adds one.
REQ-011 mem_write_strobe SHALL be 4'b0000 whenever mem_write_valid=0.
REQ-012 Back-to-back operation: store_enable high in the cycle after done SHALL start a new request.

Reset
REQ-013 reset_n=0 SHALL immediately force state IDLE and drive busy, done, mem_write_valid, mem_write_address, mem_write_data, mem_write_strobe and misaligned to 0.
REQ-014 Reset asserted during REQUEST SHALL drop mem_write_valid asynchronously, discard the store and produce no done pulse.
REQ-015 After reset_n deasserts, the first sampled store_enable SHALL start a request normally.

Configuration
REQ-016 Macro MISALIGN_TRAP_EN SHALL control misalignment handling. Misaligned means SH with ea[0]=1, or SW with ea[1:0]!=0.
REQ-017 With MISALIGN_TRAP_EN defined, a misaligned store SHALL skip REQUEST, issue no memory write, and go to DONE with misaligned=1 for that cycle.
REQ-018 With MISALIGN_TRAP_EN undefined:
- misaligned SHALL be tied to 0.
- SH SHALL use ea[0] forced to 0.
- SW SHALL use ea[1:0] forced to 0.
- The write proceeds normally.

Verification
REQ-019 SB, rs1=0x1000, imm=0x3, rs2=0xA5, ready=1 -> address 0x1000, strobe 4'b1000, data 0xA5A5A5A5, done at N+2.
REQ-020 SH, rs1=0x2000, imm=0xFFFFFFFE (-2), rs2=0x1234BEEF -> address 0x1FFC, strobe 4'b1100, data 0xBEEFBEEF.
REQ-021 SW, rs1=0x100, imm=0, rs2=0xDEADBEEF, ready low 3 cycles -> valid with outputs stable 3 cycles, handshake on cycle 4, then one done pulse.
REQ-022 SW, ea=0x102 -> with MISALIGN_TRAP_EN: no valid, done+misaligned at N+1; without it: address 0x100, strobe 4'b1111.
REQ-023 Reset pulse mid-REQUEST -> valid drops immediately, no done; a new SB after reset completes correctly.
REQ-024 funct3=3'h4 -> no valid, done at N+1, misaligned=0.
